// File: rtl/wdt_rst_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : wdt_rst_pkg
//  Description : Shared types and constants for the watchdog reset sequencer:
//                sequencer states, cause bit positions, register addresses
//                and the default software-reset key.
//  Revision    : 1.0 - initial release
// ============================================================================
package wdt_rst_pkg;

  // Encoding is visible to software through the state register
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_STAGGER = 2'd2
  } state_t;

  // Bit positions inside the cause register
  localparam int c_cause_por = 0;
  localparam int c_cause_wdt = 1;
  localparam int c_cause_ext = 2;
  localparam int c_cause_sw  = 3;

  // Avalon word addresses
  localparam logic [1:0] c_addr_cause = 2'd0;
  localparam logic [1:0] c_addr_count = 2'd1;
  localparam logic [1:0] c_addr_swrst = 2'd2;
  localparam logic [1:0] c_addr_state = 2'd3;

  // Upper byte of writedata that unlocks a software reset
  localparam logic [7:0] c_sw_key_default = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/rst_ext_filter.sv
`default_nettype none
// ============================================================================
//  Module      : rst_ext_filter
//  Description : Push-button conditioner. Two-flop synchroniser, counter of
//                consecutive low cycles and a single-cycle request pulse once
//                the button has been low for EXT_FILTER cycles. A new pulse
//                is only possible after the button is seen high again.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_ext_filter #(
  parameter int EXT_FILTER = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ext_reset_n_async,
  output logic o_pulse
);

  localparam logic [15:0] c_last = 16'(EXT_FILTER - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_cnt;
  logic        r_armed;
  logic        r_pulse;

  // Bring the asynchronous button into the clock domain; idle level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_ext_reset_n_async;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive low cycles and fire once per press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 16'd0;
      r_armed <= 1'b1;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (r_sync2) begin
        r_cnt   <= 16'd0;
        r_armed <= 1'b1;
      end else if (r_armed) begin
        if (r_cnt == c_last) begin
          r_pulse <= 1'b1;
          r_armed <= 1'b0;
          r_cnt   <= 16'd0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/wdt_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wdt_reset_sequencer
//  Description : Merges watchdog, push-button and software reset requests
//                into a stretched, staged system reset. Peripherals leave
//                reset first, the CPU STAGGER_CYCLES later. Reset cause and
//                a sequence counter are readable over a 16-bit Avalon slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module wdt_reset_sequencer
  import wdt_rst_pkg::*;
#(
  parameter int         HOLD_CYCLES    = 1000,
  parameter int         STAGGER_CYCLES = 64,
  parameter int         EXT_FILTER     = 16,
  parameter logic [7:0] SW_KEY         = c_sw_key_default
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        resetrequest,
  input  logic        ext_reset_n_async,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        periph_reset_n,
  output logic        cpu_reset_n,
  output logic        seq_busy
);

  localparam logic [15:0] c_hold_last    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] c_stagger_last = 16'(STAGGER_CYCLES - 1);

  logic        w_wr;
  logic        w_wdt_req;
  logic        w_ext_req;
  logic        w_sw_req;
  logic        w_req;
  logic        w_start;
  logic [3:0]  w_cause_set;
  logic        w_unused;

  logic        r_rr_prev;
  state_t      r_state;
  logic [15:0] r_timer;
  logic [3:0]  r_cause;
  logic [7:0]  r_count;
  logic [15:0] r_readdata;
  logic        r_periph_n;
  logic        r_cpu_n;
  logic        r_busy;

  rst_ext_filter #(
    .EXT_FILTER (EXT_FILTER)
  ) u_ext_filter (
    .clk                 (clk),
    .reset               (reset),
    .i_ext_reset_n_async (ext_reset_n_async),
    .o_pulse             (w_ext_req)
  );

  assign w_wr        = chipselect & ~write_n;
  assign w_wdt_req   = resetrequest & ~r_rr_prev;
  assign w_sw_req    = w_wr & (address == c_addr_swrst) & writedata[0]
                     & (writedata[15:8] == SW_KEY);
  assign w_req       = w_wdt_req | w_ext_req | w_sw_req;
  assign w_start     = w_req & (r_state == ST_IDLE);
  assign w_cause_set = {w_sw_req, w_ext_req, w_wdt_req, 1'b0};
  assign w_unused    = &{1'b0, writedata[7:4]};

  // Previous watchdog level for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rr_prev <= 1'b0;
    else       r_rr_prev <= resetrequest;
  end

  // Sequencer FSM; outputs are updated with each state change so they come straight from flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_ASSERT;
      r_timer    <= 16'd0;
      r_periph_n <= 1'b0;
      r_cpu_n    <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state    <= ST_ASSERT;
            r_timer    <= 16'd0;
            r_periph_n <= 1'b0;
            r_cpu_n    <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_ASSERT: begin
          if (w_req) begin
            r_timer <= 16'd0;
          end else if (r_timer == c_hold_last) begin
            r_state    <= ST_STAGGER;
            r_timer    <= 16'd0;
            r_periph_n <= 1'b1;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        ST_STAGGER: begin
          if (w_req) begin
            r_state    <= ST_ASSERT;
            r_timer    <= 16'd0;
            r_periph_n <= 1'b0;
          end else if (r_timer == c_stagger_last) begin
            r_state <= ST_IDLE;
            r_timer <= 16'd0;
            r_cpu_n <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: begin
          r_state    <= ST_ASSERT;
          r_timer    <= 16'd0;
          r_periph_n <= 1'b0;
          r_cpu_n    <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  // Cause (W1C, new events win) and saturating sequence counter (clear+start gives 1)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cause <= 4'(1 << c_cause_por);
      r_count <= 8'd0;
    end else begin
      if (w_wr && (address == c_addr_cause)) r_cause <= (r_cause & ~writedata[3:0]) | w_cause_set;
      else                                   r_cause <= r_cause | w_cause_set;

      if (w_wr && (address == c_addr_count)) r_count <= w_start ? 8'd1 : 8'd0;
      else if (w_start && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
    end
  end

  // Registered read mux, data valid the cycle after chipselect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= 16'd0;
    end else if (chipselect) begin
      case (address)
        c_addr_cause: r_readdata <= {12'd0, r_cause};
        c_addr_count: r_readdata <= {8'd0, r_count};
        c_addr_swrst: r_readdata <= 16'd0;
        default:      r_readdata <= {14'd0, r_state};
      endcase
    end
  end

  assign readdata       = r_readdata;
  assign periph_reset_n = r_periph_n;
  assign cpu_reset_n    = r_cpu_n;
  assign seq_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wdt_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wdt_reset_sequencer
//  Description : Directed bench. Register reads push their expected value
//                into a scoreboard queue; a monitor pops and compares when
//                the read data appears. A second, short-timed instance covers
//                counter saturation and clear/increment collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wdt_reset_sequencer;

  localparam int HOLD = 1000;
  localparam int STAG = 64;
  localparam int EXTF = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ext_n = 1'b1;

  logic        rr1 = 1'b0, cs1 = 1'b0, wn1 = 1'b1;
  logic [1:0]  ad1 = 2'd0;
  logic [15:0] wd1 = 16'd0;
  logic [15:0] rd1;
  logic        pr1, cr1, bz1;

  logic        rr2 = 1'b0, cs2 = 1'b0, wn2 = 1'b1;
  logic [1:0]  ad2 = 2'd0;
  logic [15:0] wd2 = 16'd0;
  logic [15:0] rd2;
  logic        pr2, cr2, bz2;

  always #5 clk = ~clk;

  wdt_reset_sequencer #(
    .HOLD_CYCLES (HOLD), .STAGGER_CYCLES (STAG), .EXT_FILTER (EXTF), .SW_KEY (8'hA5)
  ) u_dut (
    .clk (clk), .reset (reset), .resetrequest (rr1), .ext_reset_n_async (ext_n),
    .address (ad1), .chipselect (cs1), .write_n (wn1), .writedata (wd1),
    .readdata (rd1), .periph_reset_n (pr1), .cpu_reset_n (cr1), .seq_busy (bz1)
  );

  wdt_reset_sequencer #(
    .HOLD_CYCLES (4), .STAGGER_CYCLES (2), .EXT_FILTER (2), .SW_KEY (8'hA5)
  ) u_dut_short (
    .clk (clk), .reset (reset), .resetrequest (rr2), .ext_reset_n_async (ext_n),
    .address (ad2), .chipselect (cs2), .write_n (wn2), .writedata (wd2),
    .readdata (rd2), .periph_reset_n (pr2), .cpu_reset_n (cr2), .seq_busy (bz2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int    inst;
    int    exp;
    string name;
  } rd_t;
  rd_t sbq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: a read accepted at a posedge is compared at the following negedge
  logic mon1 = 1'b0, mon2 = 1'b0;
  always @(posedge clk) begin
    mon1 <= cs1 & wn1;
    mon2 <= cs2 & wn2;
  end

  always @(negedge clk) begin
    if (mon1 || mon2) begin
      if (sbq.size() == 0) begin
        chk("unexpected_read", 1, 0);
      end else begin
        rd_t e;
        e = sbq.pop_front();
        chk({e.name, "_inst"}, mon1 ? 1 : 2, e.inst);
        chk(e.name, mon1 ? int'(rd1) : int'(rd2), e.exp);
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic get_sig(input int inst, input int which);
    if (inst == 1) return (which == 0) ? pr1 : (which == 1) ? cr1 : bz1;
    else           return (which == 0) ? pr2 : (which == 1) ? cr2 : bz2;
  endfunction

  // Counts clock edges until the chosen output reaches val; timeout counts as a failure
  task automatic wait_level(input int inst, input int which, input logic val,
                            input int limit, input string name, output int n);
    bit done;
    n = 0;
    done = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      n++;
      if (get_sig(inst, which) == val) begin
        done = 1;
      end else if (n >= limit) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout after %0d cycles, level %0b never reached", name, n, val);
        done = 1;
      end
    end
  endtask

  task automatic avl_write(input int inst, input logic [1:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    if (inst == 1) begin cs1 = 1'b1; wn1 = 1'b0; ad1 = a; wd1 = d; end
    else           begin cs2 = 1'b1; wn2 = 1'b0; ad2 = a; wd2 = d; end
    @(posedge clk);
    #1;
    cs1 = 1'b0; wn1 = 1'b1; cs2 = 1'b0; wn2 = 1'b1;
  endtask

  task automatic avl_read(input int inst, input logic [1:0] a, input int exp, input string name);
    rd_t e;
    @(posedge clk);
    #1;
    if (inst == 1) begin cs1 = 1'b1; wn1 = 1'b1; ad1 = a; end
    else           begin cs2 = 1'b1; wn2 = 1'b1; ad2 = a; end
    e.inst = inst;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cs1 = 1'b0; cs2 = 1'b0;
  endtask

  task automatic pulse_wdt2();
    int n;
    rr2 = 1'b1;
    cyc(1);
    rr2 = 1'b0;
    wait_level(2, 2, 1'b0, 50, "short_seq_idle", n);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int  n;
    bit  glitch_seen;

    // ---------------- 1: power-on reset ----------------
    cyc(3);
    chk("por_periph_held", pr1, 0);
    chk("por_cpu_held", cr1, 0);
    chk("por_busy", bz1, 1);
    chk("por_readdata", rd1, 0);
    reset = 1'b0;
    wait_level(1, 0, 1'b1, HOLD + 100, "por_periph_rise", n);
    chk("por_periph_latency", n, HOLD);
    chk("por_cpu_still_held", cr1, 0);
    wait_level(1, 1, 1'b1, STAG + 50, "por_cpu_rise", n);
    chk("por_cpu_stagger", n, STAG);
    chk("por_idle_busy", bz1, 0);
    avl_read(1, 2'd0, 16'h0001, "por_cause");
    avl_read(1, 2'd1, 16'h0000, "por_count");
    avl_read(1, 2'd3, 16'h0000, "por_state");

    // ---------------- 2: watchdog edge ----------------
    cyc(1);
    rr1 = 1'b1;
    cyc(1);
    chk("wdt_periph_low", pr1, 0);
    chk("wdt_busy", bz1, 1);
    avl_read(1, 2'd3, 16'h0001, "wdt_state_assert");
    wait_level(1, 1, 1'b1, HOLD + STAG + 50, "wdt_cpu_release", n);
    cyc(20);
    chk("wdt_level_no_retrigger", bz1, 0);
    avl_read(1, 2'd0, 16'h0003, "wdt_cause");
    avl_read(1, 2'd1, 16'h0001, "wdt_count");
    rr1 = 1'b0;

    // ---------------- 3: push-button filter ----------------
    cyc(2);
    glitch_seen = 0;
    ext_n = 1'b0;
    repeat (10) begin
      cyc(1);
      if (!pr1) glitch_seen = 1;
    end
    ext_n = 1'b1;
    repeat (30) begin
      cyc(1);
      if (!pr1) glitch_seen = 1;
    end
    chk("ext_glitch_ignored", int'(glitch_seen), 0);
    ext_n = 1'b0;
    wait_level(1, 0, 1'b0, 40, "ext_periph_low", n);
    chk_rng("ext_latency_cycles", n - 1, 17, 18);
    cyc(20 - n);
    ext_n = 1'b1;
    wait_level(1, 2, 1'b0, HOLD + STAG + 50, "ext_idle", n);
    avl_read(1, 2'd0, 16'h0007, "ext_cause");
    avl_read(1, 2'd1, 16'h0002, "ext_count");

    // ---------------- 4: software key, stagger retrigger ----------------
    avl_write(1, 2'd2, 16'h0001);
    cyc(3);
    chk("sw_bad_key_ignored", bz1, 0);
    avl_write(1, 2'd2, 16'hA501);
    chk("sw_periph_low", pr1, 0);
    wait_level(1, 0, 1'b1, HOLD + 50, "sw_periph_rise", n);
    cyc(5);
    chk("sw_in_stagger_cpu", cr1, 0);
    rr1 = 1'b1;
    cyc(1);
    chk("stagger_retrigger_periph", pr1, 0);
    rr1 = 1'b0;
    wait_level(1, 2, 1'b0, HOLD + STAG + 50, "sw_idle", n);
    avl_read(1, 2'd1, 16'h0003, "sw_count_no_stretch_inc");
    avl_read(1, 2'd0, 16'h000F, "sw_cause");

    // ---------------- 5: register collisions ----------------
    avl_write(1, 2'd0, 16'h000F);
    avl_read(1, 2'd0, 16'h0000, "cause_w1c_all");
    cyc(1);
    cs1 = 1'b1; wn1 = 1'b0; ad1 = 2'd0; wd1 = 16'h0002; rr1 = 1'b1;
    cyc(1);
    cs1 = 1'b0; wn1 = 1'b1;
    avl_read(1, 2'd0, 16'h0002, "w1c_vs_wdt_set");
    rr1 = 1'b0;
    avl_read(1, 2'd1, 16'h0004, "count_after_w1c_seq");
    avl_write(1, 2'd1, 16'h0000);
    avl_read(1, 2'd1, 16'h0000, "count_cleared");
    avl_read(1, 2'd2, 16'h0000, "addr2_reads_zero");
    wait_level(1, 2, 1'b0, HOLD + STAG + 50, "w1c_idle", n);

    // short-timed instance: clear/increment collision and saturation
    avl_write(2, 2'd1, 16'h0000);
    avl_read(2, 2'd1, 16'h0000, "short_count_clear");
    pulse_wdt2();
    pulse_wdt2();
    avl_read(2, 2'd1, 16'h0002, "short_count_two");
    cyc(1);
    cs2 = 1'b1; wn2 = 1'b0; ad2 = 2'd1; wd2 = 16'h0000; rr2 = 1'b1;
    cyc(1);
    cs2 = 1'b0; wn2 = 1'b1; rr2 = 1'b0;
    avl_read(2, 2'd1, 16'h0001, "count_clear_vs_inc");
    wait_level(2, 2, 1'b0, 50, "short_idle", n);
    for (int i = 0; i < 260; i++) pulse_wdt2();
    avl_read(2, 2'd1, 16'h00FF, "count_saturate");
    avl_write(2, 2'd1, 16'h0000);
    avl_read(2, 2'd1, 16'h0000, "count_sat_clear");

    // ---------------- 6: reset mid-sequence ----------------
    cyc(2);
    rr1 = 1'b1;
    cyc(1);
    rr1 = 1'b0;
    cyc(495);
    avl_read(1, 2'd3, 16'h0001, "mid_state_assert");
    cyc(1);
    reset = 1'b1;
    #1;
    chk("midrst_periph", pr1, 0);
    chk("midrst_busy", bz1, 1);
    chk("midrst_readdata", rd1, 0);
    cyc(2);
    reset = 1'b0;
    wait_level(1, 0, 1'b1, HOLD + 100, "midrst_periph_rise", n);
    chk("midrst_periph_latency", n, HOLD);
    wait_level(1, 1, 1'b1, STAG + 50, "midrst_cpu_rise", n);
    chk("midrst_cpu_stagger", n, STAG);
    avl_read(1, 2'd0, 16'h0001, "midrst_cause");
    avl_read(1, 2'd1, 16'h0000, "midrst_count");

    cyc(5);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
